operand_bank_responder: RTL and testbench

//  Return path of the operand-collector read protocol. Consumes the per-bank scalar/vector grants
//  (valid, rsAddr, chosen slot) produced by the operand arbitration stage and drives register-bank

---
 rtl/operand_bank_responder.sv | 124 ++++++++++++
 tb/tb_operand_bank_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bank_responder.sv
// Operand-collector read return path: drives bank SRAM read ports from grants, tracks each read
// through the one-cycle SRAM latency with write-back forwarding, and routes data to operand slots.
module operand_bank_responder #(
  parameter  int NUM_BANK   = 4,
  parameter  int NUM_CU     = 4,
  parameter  int ADDR_W     = 7,
  parameter  int NUM_THREAD = 8,
  localparam int NSLOT      = 4 * NUM_CU,
  localparam int VW         = 32 * NUM_THREAD,
  localparam int CW         = $clog2(4 * NUM_CU),
  localparam int BW         = $clog2(NUM_BANK)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BANK-1:0]        scalar_valid_i,
  input  logic [ADDR_W*NUM_BANK-1:0] scalar_rsAddr_i,
  input  logic [CW*NUM_BANK-1:0]     chosen_scalar_i,
  input  logic [NUM_BANK-1:0]        vector_valid_i,
  input  logic [ADDR_W*NUM_BANK-1:0] vector_rsAddr_i,
  input  logic [CW*NUM_BANK-1:0]     chosen_vector_i,
  output logic [NUM_BANK-1:0]        sbank_rd_en_o,
  output logic [ADDR_W*NUM_BANK-1:0] sbank_rd_addr_o,
  input  logic [32*NUM_BANK-1:0]     sbank_rd_data_i,
  output logic [NUM_BANK-1:0]        vbank_rd_en_o,
  output logic [ADDR_W*NUM_BANK-1:0] vbank_rd_addr_o,
  input  logic [VW*NUM_BANK-1:0]     vbank_rd_data_i,
  input  logic                       wb_s_valid_i,
  input  logic                       wb_v_valid_i,
  input  logic [BW-1:0]              wb_bank_i,
  input  logic [ADDR_W-1:0]          wb_addr_i,
  input  logic [VW-1:0]              wb_data_i,
  input  logic                       flush_i,
  output logic [NSLOT-1:0]           resp_valid_o,
  output logic [VW*NSLOT-1:0]        resp_data_o,
  output logic                       err_dup_o
);

  function automatic logic [VW-1:0] replicate(input logic [31:0] d);
    return {NUM_THREAD{d}};
  endfunction

  logic [NUM_BANK-1:0]             s_vld_p1, v_vld_p1;
  logic [NUM_BANK-1:0]             s_hit_p1, v_hit_p1;
  logic [NUM_BANK-1:0][CW-1:0]     s_chosen_p1, v_chosen_p1;
  logic [NUM_BANK-1:0][31:0]       s_fwd_p1;
  logic [NUM_BANK-1:0][VW-1:0]     v_fwd_p1;

  logic [NSLOT-1:0]                resp_vld_p2;
  logic [NSLOT-1:0][VW-1:0]        resp_data_p2;
  logic                            err_dup_p2;

  logic [NSLOT-1:0]                nxt_vld;
  logic [NSLOT-1:0][VW-1:0]        nxt_data;
  logic                            dup;

  assign sbank_rd_en_o   = scalar_valid_i & ~{NUM_BANK{flush_i}};
  assign vbank_rd_en_o   = vector_valid_i & ~{NUM_BANK{flush_i}};
  assign sbank_rd_addr_o = scalar_rsAddr_i;
  assign vbank_rd_addr_o = vector_rsAddr_i;

  // Stage S1: capture grant, slot and forwarding decision while the SRAM read is in flight
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++) begin
      s_chosen_p1[b] <= chosen_scalar_i[b*CW +: CW];
      v_chosen_p1[b] <= chosen_vector_i[b*CW +: CW];
      s_hit_p1[b]    <= wb_s_valid_i && (wb_bank_i == BW'(b)) &&
                        (wb_addr_i == scalar_rsAddr_i[b*ADDR_W +: ADDR_W]);
      v_hit_p1[b]    <= wb_v_valid_i && (wb_bank_i == BW'(b)) &&
                        (wb_addr_i == vector_rsAddr_i[b*ADDR_W +: ADDR_W]);
      s_fwd_p1[b]    <= wb_data_i[31:0];
      v_fwd_p1[b]    <= wb_data_i;
    end
  end

  // Slot routing; lowest bank, scalar before vector, claims a contested slot
  always_comb begin
    nxt_vld  = '0;
    nxt_data = '0;
    dup      = 1'b0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (s_vld_p1[b] && (int'(s_chosen_p1[b]) < NSLOT)) begin
        if (nxt_vld[s_chosen_p1[b]]) begin
          dup = 1'b1;
        end else begin
          nxt_vld[s_chosen_p1[b]]  = 1'b1;
          nxt_data[s_chosen_p1[b]] = replicate(s_hit_p1[b] ? s_fwd_p1[b]
                                                           : sbank_rd_data_i[b*32 +: 32]);
        end
      end
      if (v_vld_p1[b] && (int'(v_chosen_p1[b]) < NSLOT)) begin
        if (nxt_vld[v_chosen_p1[b]]) begin
          dup = 1'b1;
        end else begin
          nxt_vld[v_chosen_p1[b]]  = 1'b1;
          nxt_data[v_chosen_p1[b]] = v_hit_p1[b] ? v_fwd_p1[b] : vbank_rd_data_i[b*VW +: VW];
        end
      end
    end
  end

  // Stage S2: registered responses; flush drops both new captures and entries due next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld_p1     <= '0;
      v_vld_p1     <= '0;
      resp_vld_p2  <= '0;
      resp_data_p2 <= '0;
      err_dup_p2   <= 1'b0;
    end else begin
      s_vld_p1    <= scalar_valid_i & ~{NUM_BANK{flush_i}};
      v_vld_p1    <= vector_valid_i & ~{NUM_BANK{flush_i}};
      resp_vld_p2 <= flush_i ? '0 : nxt_vld;
      for (int s = 0; s < NSLOT; s++) begin
        if (nxt_vld[s] && !flush_i) resp_data_p2[s] <= nxt_data[s];
      end
      if (dup && !flush_i) err_dup_p2 <= 1'b1;
    end
  end

  assign resp_valid_o = resp_vld_p2;
  assign resp_data_o  = resp_data_p2;
  assign err_dup_o    = err_dup_p2;

endmodule

// File: tb/tb_operand_bank_responder.sv
// Scoreboard bench for operand_bank_responder: directed grants push expected slot data, a
// negedge monitor pops entries due each cycle and compares valids, data and the dup flag.
module tb_operand_bank_responder;
  localparam int NB = 4, NCU = 4, AW = 7, NT = 8;
  localparam int NSLOT = 16, VW = 256, CW = 4, BW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0]      scalar_valid, vector_valid;
  logic [AW*NB-1:0]   scalar_rsaddr, vector_rsaddr;
  logic [CW*NB-1:0]   chosen_scalar, chosen_vector;
  logic [NB-1:0]      sbank_rd_en, vbank_rd_en;
  logic [AW*NB-1:0]   sbank_rd_addr, vbank_rd_addr;
  logic [32*NB-1:0]   sbank_rd_data;
  logic [VW*NB-1:0]   vbank_rd_data;
  logic               wb_s_valid, wb_v_valid, flush;
  logic [BW-1:0]      wb_bank;
  logic [AW-1:0]      wb_addr;
  logic [VW-1:0]      wb_data;
  logic [NSLOT-1:0]   resp_valid;
  logic [VW*NSLOT-1:0] resp_data;
  logic               err_dup;

  operand_bank_responder #(.NUM_BANK(NB), .NUM_CU(NCU), .ADDR_W(AW), .NUM_THREAD(NT)) dut (
    .clk(clk), .rst(rst),
    .scalar_valid_i(scalar_valid), .scalar_rsAddr_i(scalar_rsaddr), .chosen_scalar_i(chosen_scalar),
    .vector_valid_i(vector_valid), .vector_rsAddr_i(vector_rsaddr), .chosen_vector_i(chosen_vector),
    .sbank_rd_en_o(sbank_rd_en), .sbank_rd_addr_o(sbank_rd_addr), .sbank_rd_data_i(sbank_rd_data),
    .vbank_rd_en_o(vbank_rd_en), .vbank_rd_addr_o(vbank_rd_addr), .vbank_rd_data_i(vbank_rd_data),
    .wb_s_valid_i(wb_s_valid), .wb_v_valid_i(wb_v_valid), .wb_bank_i(wb_bank),
    .wb_addr_i(wb_addr), .wb_data_i(wb_data), .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .err_dup_o(err_dup)
  );

  always #5 clk = ~clk;

  // Read-before-write SRAM model
  logic [31:0]   smem [NB][128];
  logic [VW-1:0] vmem [NB][128];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (sbank_rd_en[b]) sbank_rd_data[b*32 +: 32] <= smem[b][sbank_rd_addr[b*AW +: AW]];
      if (vbank_rd_en[b]) vbank_rd_data[b*VW +: VW] <= vmem[b][vbank_rd_addr[b*AW +: AW]];
    end
    if (wb_s_valid) smem[wb_bank][wb_addr] <= wb_data[31:0];
    if (wb_v_valid) vmem[wb_bank][wb_addr] <= wb_data;
  end

  typedef struct {int due; int slot; logic [VW-1:0] data;} exp_t;
  exp_t sbq[$];
  exp_t keep_q[$];
  int cyc = 0;
  int checks = 0, fails = 0;
  int err_due = 1 << 30;
  bit mon_en = 1'b0;
  logic [NSLOT-1:0] ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ev = '0;
      keep_q = {};
      foreach (sbq[i]) begin
        if (sbq[i].due == cyc) begin
          ev[sbq[i].slot] = 1'b1;
          check($sformatf("slot%0d_data", sbq[i].slot), resp_data[sbq[i].slot*VW +: VW], sbq[i].data);
        end else begin
          keep_q.push_back(sbq[i]);
        end
      end
      sbq = keep_q;
      check("resp_valid", VW'(resp_valid), VW'(ev));
      check("err_dup", VW'(err_dup), VW'(cyc >= err_due));
    end
  end

  task automatic clear_inputs();
    scalar_valid = '0; vector_valid = '0; scalar_rsaddr = '0; vector_rsaddr = '0;
    chosen_scalar = '0; chosen_vector = '0;
    wb_s_valid = 1'b0; wb_v_valid = 1'b0; wb_bank = '0; wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Set wb_* before calling so same-cycle forwarding enters the expectation
  task automatic grant_s(input int b, input int a, input int slot, input bit push);
    exp_t e;
    scalar_valid[b] = 1'b1;
    scalar_rsaddr[b*AW +: AW] = AW'(a);
    chosen_scalar[b*CW +: CW] = CW'(slot);
    if (push) begin
      e.due = cyc + 2; e.slot = slot;
      e.data = (wb_s_valid && wb_bank == BW'(b) && wb_addr == AW'(a)) ?
               {NT{wb_data[31:0]}} : {NT{smem[b][a]}};
      sbq.push_back(e);
    end
  endtask

  task automatic grant_v(input int b, input int a, input int slot, input bit push);
    exp_t e;
    vector_valid[b] = 1'b1;
    vector_rsaddr[b*AW +: AW] = AW'(a);
    chosen_vector[b*CW +: CW] = CW'(slot);
    if (push) begin
      e.due = cyc + 2; e.slot = slot;
      e.data = (wb_v_valid && wb_bank == BW'(b) && wb_addr == AW'(a)) ? wb_data : vmem[b][a];
      sbq.push_back(e);
    end
  endtask

  int sa[NB], va[NB];
  logic [VW-1:0] sram_old;

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 128; a++) begin
        smem[b][a] = 32'h1000_0000 * (b + 1) + 32'h101 * a;
        for (int l = 0; l < NT; l++) vmem[b][a][l*32 +: 32] = 32'h8000_0000 + 32'h0100_0000 * b + 32'h100 * a + l;
      end
    smem[2][5] = 32'hA5A5_0001;
    sbank_rd_data = '0; vbank_rd_data = '0;
    clear_inputs();
    rst = 1'b1;
    step(); step();
    check("reset_resp_valid", VW'(resp_valid), '0);
    check("reset_resp_data_nonzero", VW'(|resp_data), '0);
    check("reset_err_dup", VW'(err_dup), '0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // Scalar bank2 addr5 -> slot6
    grant_s(2, 5, 6, 1'b1);
    #1;
    check("sbank_rd_en", VW'(sbank_rd_en), VW'(4'b0100));
    check("sbank_rd_addr_b2", VW'(sbank_rd_addr[2*AW +: AW]), VW'(5));
    step(); step(); step(); step();

    // Same-cycle vector write-back forwards; scalar write-back to same place does not
    wb_v_valid = 1'b1; wb_bank = 2'd0; wb_addr = 7'd3; wb_data = {8{32'hCAFE_F00D}};
    grant_v(0, 3, 1, 1'b1);
    step(); step(); step();
    grant_v(0, 3, 1, 1'b1);
    step();
    wb_v_valid = 1'b1; wb_bank = 2'd0; wb_addr = 7'd3; wb_data = {8{32'h1234_5678}};
    step(); step(); step();
    sram_old = vmem[1][9];
    wb_s_valid = 1'b1; wb_bank = 2'd1; wb_addr = 7'd9; wb_data = {8{32'h0BAD_0BAD}};
    grant_v(1, 9, 12, 1'b1);
    step(); step(); step();
    check("vec_vs_scalar_wb_isolation", vmem[1][9], sram_old);

    // Full load: 8 grants per cycle to 8 distinct slots for 20 cycles, some forwarded
    for (int i = 0; i < 20; i++) begin
      for (int b = 0; b < NB; b++) begin
        sa[b] = (i * 7 + b * 13) % 128;
        va[b] = (i * 11 + b * 5 + 1) % 128;
      end
      wb_s_valid = (i % 3 != 0);
      wb_v_valid = (i % 2 == 0);
      wb_bank = BW'(i % 4);
      wb_addr = wb_s_valid ? AW'(sa[i % 4]) : AW'(va[i % 4]);
      wb_data = {8{32'hF000_0000 + 32'(i)}} ^ {224'd0, 32'(i * 3)};
      for (int b = 0; b < NB; b++) begin
        grant_s(b, sa[b], (i + 2 * b) % NSLOT, 1'b1);
        grant_v(b, va[b], (i + 2 * b + 1) % NSLOT, 1'b1);
      end
      step();
    end
    step(); step(); step();

    // Bank1 and bank3 scalar both to slot4: bank1 wins, dup flag sticks
    grant_s(1, 10, 4, 1'b1);
    grant_s(3, 11, 4, 1'b0);
    err_due = cyc + 2;
    step(); step(); step(); step();
    grant_s(0, 20, 3, 1'b1);
    step(); step(); step();

    // Flush kills the in-flight grant and the same-cycle grant
    grant_s(0, 1, 0, 1'b0);
    grant_v(1, 2, 9, 1'b0);
    step();
    flush = 1'b1;
    grant_s(2, 3, 2, 1'b0);
    #1;
    check("flush_gates_rd_en", VW'(sbank_rd_en), '0);
    step();
    grant_s(0, 4, 0, 1'b1);
    grant_v(3, 6, 15, 1'b1);
    step(); step(); step(); step();
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d responses never arrived, required 0", sbq.size());
    end

    // Reset with S1 full clears everything including the sticky dup flag
    mon_en = 1'b0;
    for (int b = 0; b < NB; b++) grant_s(b, b, b, 1'b0);
    step();
    rst = 1'b1;
    step();
    check("rst_resp_valid", VW'(resp_valid), '0);
    check("rst_resp_data_nonzero", VW'(|resp_data), '0);
    check("rst_err_dup", VW'(err_dup), '0);
    rst = 1'b0;
    step();
    check("post_rst_resp_valid", VW'(resp_valid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
